// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and constants for the FIFO read-side arbiter.
//   arb_state_e : arbiter FSM states
//   id_width()  : width of a consumer index, never below 1
//   CntW        : burst pop counter width
package fifo_rd_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    localparam int unsigned CntW = 8;

    function automatic int unsigned id_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
//   req_i   : request vector
//   start_i : index searched first; the search wraps modulo N
//   gnt_o   : one-hot winner
//   idx_o   : winner index
//   valid_o : any request present
module rr_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int unsigned j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (int'(start_i) + i) % N;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: shares the FIFO read port between NUM_REQ consumers.
// Grants round-robin, holding a grant for up to MAX_BURST pops, and returns
// each popped word tagged with its consumer index one cycle after the pop.
// Optional macro FIFO_RD_ARB_PRIO_EN: consumer 0 wins every arbitration it
// takes part in; the others share round-robin. No preemption inside a burst.
//   rd_clk_i        : read-domain clock
//   rd_rst_ni       : asynchronous active-low reset
//   req_i / ready_i : per-consumer request level / ready to take a word
//   fifo_empty_i    : FIFO empty flag
//   fifo_rd_data_i  : FIFO head word
//   fifo_rd_en_o    : pop strobe (combinational)
//   gnt_o           : one-hot grant, registered
//   out_valid_o     : popped-word pulse; out_data_o / out_id_o word and owner
//   busy_o          : high while a grant is held
module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned ID_W      = id_width(NUM_REQ)
) (
    input  logic                 rd_clk_i,
    input  logic                 rd_rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   ready_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_SIZE-1:0] fifo_rd_data_i,
    output logic                 fifo_rd_en_o,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic                 out_valid_o,
    output logic [DATA_SIZE-1:0] out_data_o,
    output logic [ID_W-1:0]      out_id_o,
    output logic                 busy_o
);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]     gidx_q, gidx_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                out_valid_q;
    logic [DATA_SIZE-1:0] out_data_q;
    logic [ID_W-1:0]     out_id_q;

    logic [ID_W-1:0]     start_idx;
    logic [NUM_REQ-1:0]  pick_req;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_valid;
    logic [NUM_REQ-1:0]  win_gnt;
    logic [ID_W-1:0]     win_idx;
    logic                win_valid;
    logic                rd_en;

    assign start_idx = (last_q == ID_W'(NUM_REQ - 1)) ? '0 : last_q + ID_W'(1);

`ifdef FIFO_RD_ARB_PRIO_EN
    // Consumer 0 is masked out of the rotation and wins outright when asking.
    assign pick_req = {req_i[NUM_REQ-1:1], 1'b0};
    always_comb begin
        win_gnt   = pick_gnt;
        win_idx   = pick_idx;
        win_valid = pick_valid;
        if (req_i[0]) begin
            win_gnt    = '0;
            win_gnt[0] = 1'b1;
            win_idx    = '0;
            win_valid  = 1'b1;
        end
    end
`else
    assign pick_req  = req_i;
    assign win_gnt   = pick_gnt;
    assign win_idx   = pick_idx;
    assign win_valid = pick_valid;
`endif

    rr_picker #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_picker (
        .req_i   (pick_req),
        .start_i (start_idx),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    gnt_d   = win_gnt;
                    gidx_d  = win_idx;
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                // req is part of the pop term, so a dropping request never pops.
                rd_en = req_i[gidx_q] & ready_i[gidx_q] & ~fifo_empty_i;
                if (rd_en) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (!req_i[gidx_q] || (rd_en && (cnt_d == CntW'(MAX_BURST)))) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rd_clk_i or negedge rd_rst_ni) begin
        if (!rd_rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge rd_clk_i or negedge rd_rst_ni) begin
        if (!rd_rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= rd_en;
            if (rd_en) begin
                out_data_q <= fifo_rd_data_i;
                out_id_q   <= gidx_q;
            end
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign gnt_o        = gnt_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_id_o     = out_id_q;
    assign busy_o       = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a queue stands in for the FIFO and
// each scenario task checks its own hand-computed expectations.
module tb_fifo_rd_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ready;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic [3:0] gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic       busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  fq[$];

    always #5 clk = ~clk;

    fifo_rd_arbiter #(
        .NUM_REQ   (4),
        .DATA_SIZE (8),
        .MAX_BURST (8)
    ) dut (
        .rd_clk_i       (clk),
        .rd_rst_ni      (rst_n),
        .req_i          (req),
        .ready_i        (ready),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_data_i (fifo_rd_data),
        .fifo_rd_en_o   (fifo_rd_en),
        .gnt_o          (gnt),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .out_id_o       (out_id),
        .busy_o         (busy)
    );

    task automatic refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // One clock: the FIFO model pops if rd_en was high before the edge.
    task automatic step();
        logic pre;
        #1;
        pre = fifo_rd_en;
        @(posedge clk);
        if (pre && fq.size() != 0) void'(fq.pop_front());
        #1;
        refresh();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 4'b1111;
        fq.delete();
        refresh();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({gnt, busy, out_valid, fifo_rd_en, out_id, out_data} !== 16'h0) begin
            n_err++;
            $display("FAIL reset: gnt=%b busy=%b ov=%b rd_en=%b id=%0d data=%h, want all 0",
                     gnt, busy, out_valid, fifo_rd_en, out_id, out_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
        refresh();
        req = 4'b0001;
        step();
        n_vec++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b busy=%b, want 0001/1", gnt, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'hA1 + 8'(i) || out_id !== 2'd0) begin
                n_err++;
                $display("FAIL single_pop%0d: ov=%b data=%h id=%0d, want 1/%h/0",
                         i, out_valid, out_data, out_id, 8'hA1 + 8'(i));
            end
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0 || gnt !== 4'b0001 || fifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_hold: ov=%b gnt=%b rd_en=%b, want 0/0001/0",
                     out_valid, gnt, fifo_rd_en);
        end
        req = 4'b0000;
        step();
        n_vec++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        int unsigned n = 0;
        int unsigned exp_t;
        do_reset();
        for (int i = 0; i < 40; i++) fq.push_back(8'(i));
        refresh();
        req = 4'b1111;
        for (int unsigned t = 1; t <= 50; t++) begin
            step();
            n_vec++;
            if (fifo_rd_en && fifo_empty) begin
                n_err++;
                $display("FAIL rr_masked_read: rd_en=1 empty=1 at step %0d", t);
            end
            if (out_valid === 1'b1) begin
                // 8 pops, then one dead cycle before the next burst's first word.
                exp_t = 2 + n + n / 8;
                n_vec++;
                if (t != exp_t || out_id !== 2'((n / 8) % 4) || out_data !== 8'(n)) begin
                    n_err++;
                    $display("FAIL rr_word%0d: step=%0d id=%0d data=%h, want step=%0d id=%0d data=%h",
                             n, t, out_id, out_data, exp_t, (n / 8) % 4, n);
                end
                n++;
            end
        end
        n_vec++;
        if (n != 40) begin
            n_err++;
            $display("FAIL rr_count: got %0d words, want 40", n);
        end
    endtask

    task automatic test_empty_stall();
        do_reset();
        for (int i = 0; i < 3; i++) fq.push_back(8'hB0 + 8'(i));
        refresh();
        req = 4'b0001;
        repeat (4) step();
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (fifo_rd_en !== 1'b0 || gnt !== 4'b0001 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL empty_stall%0d: rd_en=%b gnt=%b ov=%b, want 0/0001/0",
                         i, fifo_rd_en, gnt, out_valid);
            end
        end
        fq.push_back(8'hB3); fq.push_back(8'hB4);
        refresh();
        step(); step();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hB4) begin
            n_err++;
            $display("FAIL empty_resume: ov=%b data=%h, want 1/b4", out_valid, out_data);
        end
        step();
        for (int i = 5; i <= 8; i++) fq.push_back(8'hB0 + 8'(i));
        refresh();
        step(); step(); step();
        // Eighth pop of the burst (B7): grant must drop with it.
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hB7 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL empty_burst_end: ov=%b data=%h gnt=%b, want 1/b7/0000",
                     out_valid, out_data, gnt);
        end
        step();
        n_vec++;
        if (gnt !== 4'b0001 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL empty_regrant: gnt=%b ov=%b, want 0001/0", gnt, out_valid);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hB8) begin
            n_err++;
            $display("FAIL empty_next: ov=%b data=%h, want 1/b8", out_valid, out_data);
        end
    endtask

    task automatic test_ready_stall();
        do_reset();
        for (int i = 0; i < 6; i++) fq.push_back(8'hC0 + 8'(i));
        refresh();
        req = 4'b0001;
        step(); step(); step();
        ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0 || gnt !== 4'b0001) begin
                n_err++;
                $display("FAIL ready_stall%0d: ov=%b rd_en=%b gnt=%b, want 0/0/0001",
                         i, out_valid, fifo_rd_en, gnt);
            end
        end
        ready = 4'b1111;
        for (int i = 2; i < 6; i++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'hC0 + 8'(i)) begin
                n_err++;
                $display("FAIL ready_resume%0d: ov=%b data=%h, want 1/%h",
                         i, out_valid, out_data, 8'hC0 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(8'hD0 + 8'(i));
        refresh();
        req = 4'b0001;
        step(); step();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (gnt !== 4'b0000 || fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: gnt=%b rd_en=%b ov=%b busy=%b, want 0000/0/0/0",
                     gnt, fifo_rd_en, out_valid, busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        req = 4'b1111;
        step();
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_regrant: gnt=%b, want 0001", gnt);
        end
    endtask

    task automatic test_prio();
        logic [3:0] exp_next;
        do_reset();
        for (int i = 0; i < 30; i++) fq.push_back(8'(i));
        refresh();
        req = 4'b1110;
        step();
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL prio_first: gnt=%b, want 0010", gnt);
        end
        step(); step(); step();
        req = 4'b1111;
        repeat (5) step();
        n_vec++;
        if (gnt !== 4'b0000 || out_id !== 2'd1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL prio_burst_end: gnt=%b id=%0d ov=%b, want 0000/1/1",
                     gnt, out_id, out_valid);
        end
        step();
`ifdef FIFO_RD_ARB_PRIO_EN
        exp_next = 4'b0001;
`else
        exp_next = 4'b0100;
`endif
        n_vec++;
        if (gnt !== exp_next) begin
            n_err++;
            $display("FAIL prio_next: gnt=%b, want %b", gnt, exp_next);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_empty_stall();
        test_ready_stall();
        test_reset_mid();
        test_prio();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Read-side arbiter that shares the single read port of the asynchronous FIFO between `NUM_REQ` consumers in the `rd_clk` domain. It grants consumers in round-robin order, holding each grant for a burst of up to `MAX_BURST` pops. It drives the FIFO read enable from the FIFO empty flag and per-consumer ready, then returns each popped word tagged with the consumer ID. It sits between the FIFO empty/read-pointer logic and the consumer blocks.

## Interface
- `NUM_REQ`, 4, number of consumers (2..8)
- `DATA_SIZE`, 8, FIFO word width
- `MAX_BURST`, 8, maximum pops per grant (1..255)
- `rd_clk`  in  1  read-domain clock; all logic on its rising edge
- `rd_rst`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-consumer request, level
- `ready`  in  NUM_REQ  per-consumer ready to accept a word
- `fifo_empty`  in  1  registered empty flag from the FIFO read side
- `fifo_rd_data`  in  DATA_SIZE  head word of the FIFO; valid while `fifo_empty`=0
- `fifo_rd_en`  out  1  pop request to the FIFO (combinational)
- `gnt`  out  NUM_REQ  one-hot current grant, registered
- `out_valid`  out  1  popped word valid, one-cycle pulse
- `out_data`  out  DATA_SIZE  popped word, registered
- `out_id`  out  ID_W  index of the consumer that owns `out_data`; ID_W = max(1, clog2(NUM_REQ))
- `busy`  out  1  high while in BURST

## Operation
- Two-state FSM:
  - IDLE: `gnt`=0. If any `req` bit is set, pick a winner round-robin, starting the search at `last+1` mod NUM_REQ. Load `gnt` and the burst counter with 0, then go to BURST.
  - BURST: `fifo_rd_en` = `req[g] & ready[g] & ~fifo_empty`, where g is the granted index.
- Pop accounting and burst end:
  - Each pop increments the counter.
  - Go to IDLE on a pop that makes the counter equal `MAX_BURST`, or when `req[g]`=0.
  - Entering IDLE clears `gnt` and sets `last`=g.
- An empty FIFO stalls the burst without losing the grant. `fifo_empty` or `ready[g]` low simply blocks pops.
- Each pop registers `fifo_rd_data` into `out_data`, sets `out_id`=g, and pulses `out_valid`.
- Counter width: 8 bits, no wrap possible because the burst ends at `MAX_BURST`.
- `fifo_rd_en` is never asserted while `fifo_empty`=1. The FIFO therefore never sees a masked read.
- Reset values: state IDLE, `gnt`=0, `last`=NUM_REQ-1 (so consumer 0 wins first), counter 0, `out_valid`=0, `out_data`=0, `out_id`=0, `busy`=0, `fifo_rd_en`=0.

## Timing
- Request to grant: `req` sampled high in IDLE at edge N gives `gnt` and `busy` high after edge N. The first pop can happen in cycle N+1.
- Pop to output latency: a pop in cycle k gives `out_valid`, `out_data` and `out_id` valid in cycle k+1 for exactly one cycle. Back-to-back pops give back-to-back valids.
- Burst-end gap: one IDLE cycle between bursts. The next grant is visible two cycles after the last pop cycle.
- Simultaneous events:
  - `req[g]` dropping in the same cycle as a pop: no pop, because `fifo_rd_en` includes `req[g]`. The FSM leaves BURST.
  - Final pop of a burst while other consumers request: that pop completes, then IDLE, then the next consumer in round-robin order is granted.
- Reset mid-burst: asserting `rd_rst` immediately forces IDLE and drops `fifo_rd_en` and `gnt`. A word in flight on `out_data` is discarded (`out_valid`=0).

## Configuration
- `FIFO_RD_ARB_PRIO_EN` defined: consumer 0 is high priority. In IDLE, if `req[0]`=1 it wins regardless of `last`. Round-robin applies among consumers 1..NUM_REQ-1 only when `req[0]`=0. There is no preemption inside a burst.
- Not defined: pure round-robin across all consumers.

## Structure
- Package `fifo_rd_arb_pkg` holds:
  - the state enum (IDLE, BURST)
  - the ID width function: max(1, clog2(n))
  - the counter width constant (8)
- Sub-module `rr_picker`: combinational one-hot round-robin priority encoder.
  - Inputs: `req` vector and start index.
  - Outputs: one-hot winner, winner index, any-valid.
  - Instantiated once. The priority override lives in the parent.

## Test plan
- Reset, then `req`=4'b0001 and 3 words in the FIFO with `ready` high: `gnt`=0001 one cycle later. Three pops occur, giving `out_valid` on 3 consecutive cycles with `out_id`=0 and data in FIFO order. The FSM holds BURST until `req[0]` drops.
- `req`=4'b1111, 40 words, `MAX_BURST`=8, all ready: grants in order 0,1,2,3,0. Exactly 8 pops per grant, with a one-cycle gap between bursts.
- FIFO goes empty mid-burst after 3 pops: `fifo_rd_en` stays 0 and `gnt` holds. After 2 words arrive, pops resume and the counter continues from 3.
- `ready[g]` low for 4 cycles mid-burst: no pops and no `out_valid` in those cycles. No word is lost or duplicated.
- Assert `rd_rst` in the middle of a burst with a pop pending: `gnt`=0, `fifo_rd_en`=0 and `out_valid`=0 immediately. After release, consumer 0 is granted first.
- With `FIFO_RD_ARB_PRIO_EN`, `req`=4'b1110 then `req[0]` rises during consumer 1's burst: consumer 1 completes its burst, then consumer 0 is granted ahead of 2 and 3.
